// File: rtl/io_responder_pkg.sv
// io_responder_pkg: register map addresses and active-low 7-segment codes.
`default_nettype none
package io_responder_pkg;

  localparam logic [7:0] ADDR_LED    = 8'h00;
  localparam logic [7:0] ADDR_SW     = 8'h04;
  localparam logic [7:0] ADDR_BTN    = 8'h08;
  localparam logic [7:0] ADDR_SEG    = 8'h0C;
  localparam logic [7:0] ADDR_STATUS = 8'h10;

  // Cathode patterns {dp,g,f,e,d,c,b,a}, active-low, dp off.
  localparam logic [7:0] SEG7_CODE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage
`default_nettype wire

// File: rtl/io_responder_debouncer.sv
// debouncer: 2-flop synchroniser followed by a stable-count filter on a WIDTH-bit group.
`default_nettype none
module debouncer #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam int            CW   = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (sync1 != sync2) begin
        // The synced value is about to change, so the current run is void.
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_responder_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low cathode decode.
`default_nettype none
module hex_to_seg7
  import io_responder_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG7_CODE[nibble];

endmodule
`default_nettype wire

// File: rtl/io_responder.sv
// io_responder: memory-mapped LED / switch / button / 7-segment device for the CPU IO port.
`default_nettype none
module io_responder
  import io_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  io_addr,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic [15:0] sw_in,
  input  logic        btn_confirm,
  output logic [15:0] led_out,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int            DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [15:0]   led_reg;
  logic [15:0]   seg_reg;
  logic [15:0]   sw_stable;
  logic          btn_stable;
  logic          btn_prev;
  logic          pending;
  logic [DW-1:0] div_cnt;
  logic [1:0]    digit;
  logic [3:0]    nibble;
  logic          btn_read;

  debouncer #(.WIDTH(16), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk    (clk),
    .reset  (reset),
    .din    (sw_in),
    .stable (sw_stable)
  );

  debouncer #(.WIDTH(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk    (clk),
    .reset  (reset),
    .din    (btn_confirm),
    .stable (btn_stable)
  );

  assign btn_read = io_read && (io_addr == ADDR_BTN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg  <= '0;
      seg_reg  <= '0;
      btn_prev <= 1'b0;
      pending  <= 1'b0;
      div_cnt  <= '0;
      digit    <= '0;
    end else begin
      if (io_write && io_addr == ADDR_LED) led_reg <= io_wdata;
      if (io_write && io_addr == ADDR_SEG) seg_reg <= io_wdata;
      btn_prev <= btn_stable;
      // A new press outranks a simultaneous read-clear so no event is lost.
      if (btn_stable && !btn_prev) pending <= 1'b1;
      else if (btn_read)           pending <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        digit   <= digit + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_read) begin
      case (io_addr)
        ADDR_LED:    io_rdata = led_reg;
        ADDR_SW:     io_rdata = sw_stable;
        ADDR_BTN:    io_rdata = {15'b0, pending};
        ADDR_SEG:    io_rdata = seg_reg;
        ADDR_STATUS: io_rdata = {15'b0, btn_stable};
        default:     io_rdata = '0;
      endcase
    end
  end

  assign led_out = led_reg;
  assign seg_an  = ~(4'b0001 << digit);
  assign nibble  = seg_reg[{digit, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_cat)
  );

endmodule
`default_nettype wire

// File: tb/tb_io_responder.sv
// tb_io_responder: directed self-checking bench for io_responder with short debounce and scan periods.
`default_nettype none
module tb_io_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  io_addr = '0;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [15:0] io_wdata = '0;
  logic [15:0] io_rdata;
  logic [15:0] sw_in = '0;
  logic        btn_confirm = 1'b0;
  logic [15:0] led_out;
  logic [3:0]  seg_an;
  logic [7:0]  seg_cat;

  int checks = 0;
  int failures = 0;

  io_responder #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_addr     (io_addr),
    .io_read     (io_read),
    .io_write    (io_write),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .sw_in       (sw_in),
    .btn_confirm (btn_confirm),
    .led_out     (led_out),
    .seg_an      (seg_an),
    .seg_cat     (seg_cat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (led_out !== 16'h0000) begin failures++; $display("FAIL reset_led got=%h exp=0000", led_out); end
    checks++; if (seg_an !== 4'b1110) begin failures++; $display("FAIL reset_an got=%b exp=1110", seg_an); end
    checks++; if (seg_cat !== 8'hC0) begin failures++; $display("FAIL reset_cat got=%h exp=c0", seg_cat); end
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", io_rdata); end
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_led();
    io_addr = 8'h00; io_wdata = 16'hA5A5; io_write = 1'b1;
    cyc();
    io_write = 1'b0;
    checks++; if (led_out !== 16'hA5A5) begin failures++; $display("FAIL led_out got=%h exp=a5a5", led_out); end
    io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'hA5A5) begin failures++; $display("FAIL led_read got=%h exp=a5a5", io_rdata); end
    io_read = 1'b0; #1;
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL idle_rdata got=%h exp=0000", io_rdata); end
    io_read = 1'b1; io_write = 1'b1; io_wdata = 16'h1234; #1;
    checks++; if (io_rdata !== 16'hA5A5) begin failures++; $display("FAIL rw_old got=%h exp=a5a5", io_rdata); end
    cyc();
    io_write = 1'b0; #1;
    checks++; if (io_rdata !== 16'h1234) begin failures++; $display("FAIL rw_new got=%h exp=1234", io_rdata); end
    io_addr = 8'h20; #1;
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL unmapped_read got=%h exp=0000", io_rdata); end
    io_read = 1'b0; io_write = 1'b1; io_wdata = 16'hFFFF;
    cyc();
    io_write = 1'b0;
    checks++; if (led_out !== 16'h1234) begin failures++; $display("FAIL unmapped_write got=%h exp=1234", led_out); end
  endtask

  task automatic test_sw_glitch(input int len);
    io_addr = 8'h04; io_read = 1'b1;
    sw_in = 16'h0F00;
    for (int k = 0; k < len; k++) cyc();
    sw_in = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      cyc();
      checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL sw_glitch%0d got=%h exp=0000", len, io_rdata); end
    end
    io_read = 1'b0;
  endtask

  task automatic test_sw_debounce();
    logic [15:0] exp;
    io_addr = 8'h04; io_read = 1'b1;
    sw_in = 16'h00F0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      exp = (k >= 6) ? 16'h00F0 : 16'h0000;
      checks++; if (io_rdata !== exp) begin failures++; $display("FAIL sw_debounce cyc%0d got=%h exp=%h", k, io_rdata, exp); end
    end
    io_read = 1'b0;
  endtask

  task automatic test_button();
    btn_confirm = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    io_addr = 8'h10; io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL btn_status_early got=%h exp=0000", io_rdata); end
    io_read = 1'b0;
    cyc();
    io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'h0001) begin failures++; $display("FAIL btn_status got=%h exp=0001", io_rdata); end
    io_read = 1'b0;
    cyc();
    io_addr = 8'h08; io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'h0001) begin failures++; $display("FAIL btn_first_read got=%h exp=0001", io_rdata); end
    cyc();
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL btn_second_read got=%h exp=0000", io_rdata); end
    io_read = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL btn_held_no_reset got=%h exp=0000", io_rdata); end
    io_read = 1'b0;
    btn_confirm = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
    io_addr = 8'h08; io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL btn_release got=%h exp=0000", io_rdata); end
    io_read = 1'b0;
  endtask

  task automatic test_same_edge();
    btn_confirm = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    io_addr = 8'h08; io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL same_edge_read got=%h exp=0000", io_rdata); end
    cyc();
    checks++; if (io_rdata !== 16'h0001) begin failures++; $display("FAIL same_edge_pending got=%h exp=0001", io_rdata); end
    cyc();
    io_read = 1'b0;
    btn_confirm = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
  endtask

  task automatic test_scan();
    logic [3:0] an_tab [4];
    logic [7:0] cat_tab [4];
    int d;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    cat_tab = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    reset = 1'b1; #2; reset = 1'b0;
    io_addr = 8'h0C; io_wdata = 16'h12AF; io_write = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cyc();
      io_write = 1'b0; #1;
      d = ((k + 1) / 4) % 4;
      checks++; if (seg_an !== an_tab[d]) begin failures++; $display("FAIL scan_an step%0d got=%b exp=%b", k, seg_an, an_tab[d]); end
      checks++; if (seg_cat !== cat_tab[d]) begin failures++; $display("FAIL scan_cat step%0d got=%h exp=%h", k, seg_cat, cat_tab[d]); end
    end
    io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'h12AF) begin failures++; $display("FAIL seg_read got=%h exp=12af", io_rdata); end
    io_read = 1'b0;
  endtask

  task automatic test_async_reset();
    io_addr = 8'h00; io_wdata = 16'hBEEF; io_write = 1'b1;
    cyc();
    io_write = 1'b0;
    btn_confirm = 1'b1;
    for (int k = 0; k < 7; k++) cyc();
    sw_in = 16'h0001;
    cyc(); cyc(); cyc();
    io_addr = 8'h08; io_read = 1'b1; #1;
    checks++; if (io_rdata !== 16'h0001) begin failures++; $display("FAIL pre_reset_pending got=%h exp=0001", io_rdata); end
    #2 reset = 1'b1; #1;
    checks++; if (led_out !== 16'h0000) begin failures++; $display("FAIL async_led got=%h exp=0000", led_out); end
    checks++; if (seg_an !== 4'b1110) begin failures++; $display("FAIL async_an got=%b exp=1110", seg_an); end
    checks++; if (seg_cat !== 8'hC0) begin failures++; $display("FAIL async_cat got=%h exp=c0", seg_cat); end
    checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL async_btn got=%h exp=0000", io_rdata); end
    btn_confirm = 1'b0;
    cyc();
    io_read = 1'b0;
    reset = 1'b0;
    io_addr = 8'h04; io_read = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 5) begin
        checks++; if (io_rdata !== 16'h0000) begin failures++; $display("FAIL abort_sw_early got=%h exp=0000", io_rdata); end
      end
      if (k == 6) begin
        checks++; if (io_rdata !== 16'h0001) begin failures++; $display("FAIL abort_sw_late got=%h exp=0001", io_rdata); end
      end
    end
    io_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_led();
    test_sw_glitch(2);
    test_sw_glitch(3);
    test_sw_debounce();
    test_button();
    test_same_edge();
    test_scan();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
